// File: rtl/seq_arith_unit.sv
// seq_arith_unit: handshaked add/inc/sub/dec unit with an optional shift-add multiplier.
// Define SEQ_ARITH_UNIT_MUL_EN to build the multiplier (op 100); otherwise op 100 is reserved.
module seq_arith_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_calc_end;
  logic [WIDTH:0]   w_full;
  logic [WIDTH-1:0] w_val;
  logic             w_c;
  logic             w_e;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_zero;
  logic             r_err;

  assign w_accept = (r_state == IDLE) && in_valid;

  // Single-cycle ops; bit WIDTH of w_full is the add carry / sub borrow.
  always_comb begin
    w_full = '0;
    w_c    = 1'b0;
    w_e    = 1'b0;
    unique case (1'b1)
      (op == 3'b000): begin
        w_full = {1'b0, X} + {1'b0, Y};
        w_c    = w_full[WIDTH];
      end
      (op == 3'b001): begin
        w_full = {1'b0, X} + {{WIDTH{1'b0}}, 1'b1};
        w_c    = &X;
      end
      (op == 3'b010): begin
        w_full = {1'b0, X} - {1'b0, Y};
        w_c    = w_full[WIDTH];
      end
      (op == 3'b011): begin
        w_full = {1'b0, X} - {{WIDTH{1'b0}}, 1'b1};
        w_c    = (X == '0);
      end
      default: w_e = 1'b1;
    endcase
  end

  assign w_val = w_full[WIDTH-1:0];

`ifdef SEQ_ARITH_UNIT_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_is_mul   = (op == 3'b100);
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_calc_end = (r_state == CALC) && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, X};
      r_mplier <= Y;
    end else if (r_state == CALC) begin
      r_cnt    <= r_cnt + CW'(1);
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_calc_end = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next = w_is_mul ? CALC : DONE;
      CALC:    if (w_calc_end) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out   <= w_val;
      r_carry <= w_c;
      r_zero  <= (w_val == '0);
      r_err   <= w_e;
    end
`ifdef SEQ_ARITH_UNIT_MUL_EN
    else if (w_calc_end) begin
      r_out   <= w_acc_nxt[WIDTH-1:0];
      r_carry <= |w_acc_nxt[2*WIDTH-1:WIDTH];
      r_zero  <= (w_acc_nxt[WIDTH-1:0] == '0);
      r_err   <= 1'b0;
    end
`endif
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out       = r_out;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign err       = r_err;

endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: directed and random stimulus against a behavioural model.
// Honors SEQ_ARITH_UNIT_MUL_EN the same way the design does.
module tb_seq_arith_unit;
  localparam int W = 16;
  localparam longint unsigned M = 64'd1 << W;
`ifdef SEQ_ARITH_UNIT_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic [2:0]   op;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out;
  logic         carry;
  logic         zero;
  logic         err;
  logic         out_valid;
  logic         out_ready;

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .X         (X),
    .Y         (Y),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .carry     (carry),
    .zero      (zero),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Result of one request from plain arithmetic on the operands.
  function automatic void calc(input logic [2:0] o,
                               input longint unsigned x,
                               input longint unsigned y,
                               output longint unsigned r,
                               output bit c, output bit e);
    longint unsigned full;
    r = 0;
    c = 1'b0;
    e = 1'b0;
    if (o == 3'd0) begin
      full = x + y;
      r = full % M;
      c = (full >= M);
    end else if (o == 3'd1) begin
      r = (x + 1) % M;
      c = (x == M - 1);
    end else if (o == 3'd2) begin
      r = (x + M - y) % M;
      c = (x < y);
    end else if (o == 3'd3) begin
      r = (x + M - 1) % M;
      c = (x == 0);
    end else if (o == 3'd4 && MUL_ON) begin
      full = x * y;
      r = full % M;
      c = (full >= M);
    end else begin
      e = 1'b1;
    end
  endfunction

  bit           m_live = 1'b0;
  bit           m_busy = 1'b0;
  bit           m_show = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_out = '0;
  bit           m_c = 1'b0;
  bit           m_z = 1'b0;
  bit           m_e = 1'b0;
  logic [W-1:0] p_out = '0;
  bit           p_c = 1'b0;
  bit           p_e = 1'b0;

  task automatic publish();
    m_out  = p_out;
    m_c    = p_c;
    m_z    = (p_out == '0);
    m_e    = p_e;
    m_show = 1'b1;
  endtask

  // Model: a request becomes visible a fixed number of edges after acceptance.
  always @(posedge clk) begin
    longint unsigned r;
    bit c;
    bit e;
    if (rst) begin
      m_live = 1'b1;
      m_busy = 1'b0;
      m_show = 1'b0;
      m_left = 0;
      m_out  = '0;
      m_c    = 1'b0;
      m_z    = 1'b0;
      m_e    = 1'b0;
    end else if (m_live) begin
      if (m_show) begin
        if (out_ready) begin
          m_show = 1'b0;
          m_busy = 1'b0;
        end
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) publish();
      end else if (in_valid) begin
        calc(op, longint'(X), longint'(Y), r, c, e);
        p_out  = r[W-1:0];
        p_c    = c;
        p_e    = e;
        m_busy = 1'b1;
        m_left = (MUL_ON && op == 3'd4) ? W : 0;
        if (m_left == 0) publish();
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, m_show);
      chk("out", out, m_out);
      chk("carry", carry, m_c);
      chk("zero", zero, m_z);
      chk("err", err, m_e);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] y);
    op = o;
    X = x;
    Y = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic chk_res(input string nm, input logic [W-1:0] o,
                         input bit c, input bit z, input bit e);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_out"}, out, o);
    chk({nm, "_carry"}, carry, c);
    chk({nm, "_zero"}, zero, z);
    chk({nm, "_err"}, err, e);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    X = '0;
    Y = '0;
    op = 3'd0;
    out_ready = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", out, 16'h0000);
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    send(3'b000, 16'hFFFF, 16'h0002);
    chk_res("add", 16'h0001, 1'b1, 1'b0, 1'b0);
    step();
    send(3'b010, 16'h0003, 16'h0005);
    chk_res("sub", 16'hFFFE, 1'b1, 1'b0, 1'b0);
    step();
    send(3'b011, 16'h0000, 16'h0000);
    chk_res("dec", 16'hFFFF, 1'b1, 1'b0, 1'b0);
    step();
    send(3'b001, 16'hFFFF, 16'h0000);
    chk_res("inc", 16'h0000, 1'b1, 1'b1, 1'b0);
    step();
    send(3'b110, 16'h1234, 16'h5678);
    chk_res("rsv", 16'h0000, 1'b0, 1'b1, 1'b1);
    step();

    send(3'b100, 16'h0100, 16'h0101);
    wait_valid(n);
    if (MUL_ON) begin
      chk("mul_lat", n, 17);
      chk_res("mul_a", 16'h0100, 1'b1, 1'b0, 1'b0);
    end else begin
      chk("mul_lat", n, 1);
      chk_res("mul_a", 16'h0000, 1'b0, 1'b1, 1'b1);
    end
    step();
    send(3'b100, 16'h0003, 16'h0005);
    wait_valid(n);
    if (MUL_ON) chk_res("mul_b", 16'h000F, 1'b0, 1'b0, 1'b0);
    else        chk_res("mul_b", 16'h0000, 1'b0, 1'b1, 1'b1);
    step();

    out_ready = 1'b0;
    send(3'b000, 16'h1111, 16'h2222);
    op = 3'b000;
    X = 16'h0005;
    Y = 16'h0006;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_res("hold", 16'h3333, 1'b0, 1'b0, 1'b0);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop_in_ready", in_ready, 1'b1);
    chk("pop_out_valid", out_valid, 1'b0);
    step();
    in_valid = 1'b0;
    chk_res("after_pop", 16'h000B, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();

    send(3'b100, 16'h1234, 16'h0037);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out", out, 16'h0000);
    chk("abort_flags", {carry, zero, err, out_valid}, 4'b0000);
    chk("abort_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 20; i++) step();
    out_ready = 1'b0;
    send(3'b000, 16'h0001, 16'h0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_done_valid", out_valid, 1'b0);
    chk("abort_done_out", out, 16'h0000);

    for (int i = 0; i < 2000; i++) begin
      int k;
      rst = ($urandom_range(0, 99) == 0);
      in_valid = $urandom_range(0, 1);
      op = 3'($urandom_range(0, 7));
      k = $urandom_range(0, 3);
      X = (k == 0) ? 16'h0000 : (k == 1) ? 16'hFFFF : 16'($urandom);
      k = $urandom_range(0, 3);
      Y = (k == 0) ? 16'h0000 : (k == 1) ? 16'hFFFF : 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_arith_unit.md
SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits; legal range 4..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port X  input  WIDTH  first operand.
REQ-005 SHALL have port Y  input  WIDTH  second operand.
REQ-006 SHALL have port op  input  3  operation code:
  - 000 X+Y
  - 001 X+1
  - 010 X-Y
  - 011 X-1
  - 100 X*Y (low WIDTH bits)
  - 101..111 reserved
REQ-007 SHALL have port in_valid  input  1  request present.
REQ-008 SHALL have port in_ready  output  1  unit can accept a request.
REQ-009 SHALL have port out  output  WIDTH  result.
REQ-010 SHALL have port carry  output  1  carry-out / borrow / multiply overflow.
REQ-011 SHALL have port zero  output  1  out equals 0.
REQ-012 SHALL have port err  output  1  request used an unsupported op.
REQ-013 SHALL have port out_valid  output  1  out, carry, zero, err are valid.
REQ-014 SHALL have port out_ready  input  1  consumer takes result.

Function
REQ-015 SHALL implement an FSM with states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with in_valid=1 and in_ready=1, registering X, Y and op; inputs outside acceptance are ignored.
REQ-017 SHALL, for op 000..011 and reserved ops, go IDLE->DONE; out_valid=1 on the cycle after acceptance (latency 1).
REQ-018 SHALL, for op 100, go IDLE->CALC and run a shift-add multiply for exactly WIDTH cycles, then CALC->DONE; out_valid=1 WIDTH+1 cycles after acceptance.
REQ-019 SHALL compute all results modulo 2^WIDTH (wrap-around, no saturation).
REQ-020 SHALL set carry as follows:
  - add: carry-out of X+Y
  - inc: 1 iff X is all ones
  - sub: 1 iff X<Y unsigned
  - dec: 1 iff X=0
  - mul: 1 iff the full 2*WIDTH-bit product has any nonzero bit above bit WIDTH-1
REQ-021 SHALL, for a reserved op, produce out=0, carry=0, zero=1, err=1; err=0 for all supported ops.
REQ-022 SHALL hold out, carry, zero, err and out_valid stable in DONE until out_ready=1; DONE->IDLE on that edge.
REQ-023 SHALL keep out_valid=0 outside DONE; out, flags retain last values (not required meaningful).
REQ-024 SHALL not accept a new request in the cycle the result is consumed; in_ready rises the cycle after DONE->IDLE.
REQ-025 SHALL ignore out_ready outside DONE and in_valid outside IDLE.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, enter IDLE and clear out, carry, zero, err, out_valid to 0 and internal accumulator/counter to 0; in_ready=1 after that edge.
REQ-027 SHALL abort any in-progress CALC or pending DONE result on reset; no result for the aborted request is ever presented.
REQ-028 SHALL give rst priority over in_valid and out_ready on the same edge.

Configuration
REQ-029 SHALL compile the multiplier when macro SEQ_ARITH_UNIT_MUL_EN is defined: op 100 behaves per REQ-018/REQ-020.
REQ-030 SHALL, without SEQ_ARITH_UNIT_MUL_EN, omit CALC logic and treat op 100 as reserved (REQ-021, latency 1).

Verification
REQ-031 SHALL cover WIDTH=16, op=000, X=0xFFFF, Y=0x0002, out_ready=1 -> next cycle out_valid=1, out=0x0001, carry=1, zero=0.
REQ-032 SHALL cover op=010, X=0x0003, Y=0x0005 -> out=0xFFFE, carry=1; then op=011, X=0x0000 -> out=0xFFFF, carry=1.
REQ-033 SHALL cover SEQ_ARITH_UNIT_MUL_EN defined, op=100, X=0x0100, Y=0x0101 -> out_valid exactly 17 cycles after acceptance, out=0x0100, carry=1; X=3, Y=5 -> out=0x000F, carry=0.
REQ-034 SHALL cover out_ready=0 for 5 cycles in DONE -> out, flags stable; in_valid=1 throughout not accepted; accepted 1 cycle after out_ready pulse.
REQ-035 SHALL cover rst=1 at cycle 4 of a multiply -> all outputs 0, in_ready=1 next cycle, no stale out_valid.
REQ-036 SHALL cover op=110 (and op=100 with macro undefined) -> out=0, zero=1, err=1, latency 1.
